mem_access_unit: RTL and testbench

MEM-stage consumer of the EX/MEM pipeline register. Turns the registered memory controls (ram_we, rf_wsel, alu_c, wdin) into req/ack transactions on the data bus and stalls the upstream pipeline until the bus responds. Drives the MEM/WB register fields (pc, have_inst, rf_we, wR, wD) for writeback. Sits between the EX/MEM register and the writeback stage; stall_o feeds the pipeline_stop inputs of the upstream pipeline registers.

---
 rtl/mem_access_unit_pkg.sv | 13 +
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions: writeback-select encodings and the MEM-stage FSM states.
package mem_access_unit_pkg;

    localparam logic [1:0] WSEL_WD  = 2'd0;
    localparam logic [1:0] WSEL_RAM = 2'd1;
    localparam logic [1:0] WSEL_ALU = 2'd2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// MEM stage: turns EX/MEM memory controls into req/ack bus transactions,
// stalls upstream while waiting, and drives the MEM/WB register fields.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              have_inst_i,
    input  logic [1:0]        rf_wsel_i,
    input  logic              rf_we_i,
    input  logic              ram_we_i,
    input  logic [DATA_W-1:0] alu_c_i,
    input  logic [DATA_W-1:0] wdin_i,
    input  logic [4:0]        wR_i,
    input  logic [DATA_W-1:0] wD_i,
    output logic              stall_o,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err_o,
    output logic [DATA_W-1:0] pc_o,
    output logic              have_inst_o,
    output logic              rf_we_o,
    output logic [4:0]        wR_o,
    output logic [DATA_W-1:0] wD_o
);

    localparam int              CNT_W    = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_mem_op;
    logic             w_timeout;

    assign w_mem_op  = have_inst_i & (ram_we_i | (rf_wsel_i == WSEL_RAM));
    assign w_timeout = (r_state == S_WAIT) && !bus_ack && (r_wait_cnt == CNT_LAST);

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        stall_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    stall_o      = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_ack || w_timeout) begin
                    w_next_state = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_err_o   <= 1'b0;
            pc_o        <= '0;
            have_inst_o <= 1'b0;
            rf_we_o     <= 1'b0;
            wR_o        <= '0;
            wD_o        <= '0;
        end else begin
            pc_o      <= pc_i;
            wR_o      <= wR_i;
            wD_o      <= wD_i;
            bus_err_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        bus_req     <= 1'b1;
                        bus_we      <= ram_we_i;
                        bus_addr    <= alu_c_i;
                        bus_wdata   <= wdin_i;
                        r_wait_cnt  <= '0;
                        have_inst_o <= 1'b0;
                        rf_we_o     <= 1'b0;
                    end else begin
                        have_inst_o <= have_inst_i;
                        rf_we_o     <= rf_we_i & have_inst_i;
                    end
                end
                S_WAIT: begin
                    if (bus_ack) begin
                        // Ack beats timeout when both land on the last wait cycle.
                        bus_req     <= 1'b0;
                        have_inst_o <= have_inst_i;
                        rf_we_o     <= rf_we_i;
                        if (rf_wsel_i == WSEL_RAM) begin
                            wD_o <= bus_rdata;
                        end
                    end else if (w_timeout) begin
                        bus_req     <= 1'b0;
                        bus_err_o   <= 1'b1;
                        have_inst_o <= have_inst_i;
                        rf_we_o     <= 1'b0;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + 1'b1;
                        have_inst_o <= 1'b0;
                        rf_we_o     <= 1'b0;
                    end
                end
                default: begin
                    bus_req     <= 1'b0;
                    have_inst_o <= 1'b0;
                    rf_we_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: an instruction-level scoreboard
// of expected MEM/WB retirements plus cycle-level bus/stall checks.
module tb_mem_access_unit;

    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 16;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] pc_i;
    logic              have_inst_i;
    logic [1:0]        rf_wsel_i;
    logic              rf_we_i;
    logic              ram_we_i;
    logic [DATA_W-1:0] alu_c_i;
    logic [DATA_W-1:0] wdin_i;
    logic [4:0]        wR_i;
    logic [DATA_W-1:0] wD_i;
    logic              stall_o;
    logic              bus_req;
    logic              bus_we;
    logic [DATA_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_err_o;
    logic [DATA_W-1:0] pc_o;
    logic              have_inst_o;
    logic              rf_we_o;
    logic [4:0]        wR_o;
    logic [DATA_W-1:0] wD_o;

    mem_access_unit #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_i        (pc_i),
        .have_inst_i (have_inst_i),
        .rf_wsel_i   (rf_wsel_i),
        .rf_we_i     (rf_we_i),
        .ram_we_i    (ram_we_i),
        .alu_c_i     (alu_c_i),
        .wdin_i      (wdin_i),
        .wR_i        (wR_i),
        .wD_i        (wD_i),
        .stall_o     (stall_o),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .bus_err_o   (bus_err_o),
        .pc_o        (pc_o),
        .have_inst_o (have_inst_o),
        .rf_we_o     (rf_we_o),
        .wR_o        (wR_o),
        .wD_o        (wD_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] pc;
        logic              have;
        logic              rf_we;
        logic [4:0]        wr;
        logic [DATA_W-1:0] wd;
        logic              err;
    } retire_t;

    retire_t sb_q[$];
    int      n_checks = 0;
    int      n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction and follows it to retirement. delay = number of
    // WAIT cycles without ack before the ack; negative means never ack.
    task automatic run_op(input logic [31:0] pc, input logic have, input logic [1:0] wsel,
                          input logic rf_we, input logic ram_we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] wr, input logic [31:0] wd,
                          input int delay, input logic [31:0] rdata);
        retire_t exp;
        retire_t got;
        logic    mem;
        logic    acked;
        int      stalls;
        int      exp_stalls;
        pc_i = pc; have_inst_i = have; rf_wsel_i = wsel; rf_we_i = rf_we; ram_we_i = ram_we;
        alu_c_i = addr; wdin_i = wdata; wR_i = wr; wD_i = wd;
        mem   = have & (ram_we | (wsel == 2'd1));
        acked = !mem || (delay >= 0 && delay < MAX_WAIT);
        exp.pc    = pc;
        exp.have  = have;
        exp.rf_we = have & rf_we & acked;
        exp.wr    = wr;
        exp.wd    = (mem && acked && wsel == 2'd1) ? rdata : wd;
        exp.err   = mem & !acked;
        sb_q.push_back(exp);
        exp_stalls = !mem ? 0 : (acked ? 1 + delay : MAX_WAIT);
        stalls = 0;
        @(negedge clk);
        if (stall_o) stalls++;
        tick();
        if (mem) begin
            check("req_rise", 64'(bus_req), 64'(1'b1));
            check("req_we", 64'(bus_we), 64'(ram_we));
            check("req_addr", 64'(bus_addr), 64'(addr));
            if (ram_we) check("req_wdata", 64'(bus_wdata), 64'(wdata));
            check("bubble_have", 64'(have_inst_o), 64'(1'b0));
            for (int k = 0; k < MAX_WAIT; k++) begin
                bus_ack   = (k == delay);
                bus_rdata = (k == delay) ? rdata : (32'hBAD0_0000 | 32'(k));
                @(negedge clk);
                if (stall_o) stalls++;
                tick();
                bus_ack = 1'b0;
                if (k == delay || k == MAX_WAIT - 1) break;
                check("req_hold", 64'(bus_req), 64'(1'b1));
                check("addr_hold", 64'(bus_addr), 64'(addr));
            end
        end
        check("stall_cycles", 64'(stalls), 64'(exp_stalls));
        check("req_low", 64'(bus_req), 64'(1'b0));
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'(1), 64'(0));
        end else begin
            exp = sb_q.pop_front();
            got.pc = pc_o; got.have = have_inst_o; got.rf_we = rf_we_o;
            got.wr = wR_o; got.wd = wD_o; got.err = bus_err_o;
            check("ret_pc", 64'(got.pc), 64'(exp.pc));
            check("ret_have", 64'(got.have), 64'(exp.have));
            check("ret_rf_we", 64'(got.rf_we), 64'(exp.rf_we));
            check("ret_wr", 64'(got.wr), 64'(exp.wr));
            check("ret_wd", 64'(got.wd), 64'(exp.wd));
            check("ret_err", 64'(got.err), 64'(exp.err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pc_i = '0; have_inst_i = 1'b0; rf_wsel_i = 2'd0; rf_we_i = 1'b0; ram_we_i = 1'b0;
        alu_c_i = '0; wdin_i = '0; wR_i = '0; wD_i = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        #12;
        check("rst_req", 64'(bus_req), 64'(1'b0));
        check("rst_err", 64'(bus_err_o), 64'(1'b0));
        check("rst_have", 64'(have_inst_o), 64'(1'b0));
        check("rst_wd", 64'(wD_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU op, load (3 waits), store (1 wait), store with writeback, reserved wsel, bubble store
        run_op(32'h100, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd5, 32'h1234, 0, 32'h0);
        run_op(32'h104, 1'b1, 2'd1, 1'b1, 1'b0, 32'h2000, 32'h0, 5'd7, 32'h55, 3, 32'hDEADBEEF);
        run_op(32'h108, 1'b1, 2'd0, 1'b0, 1'b1, 32'h3004, 32'hA5A5A5A5, 5'd0, 32'h0, 1, 32'h0);
        run_op(32'h10C, 1'b1, 2'd2, 1'b1, 1'b1, 32'h3008, 32'h11112222, 5'd9, 32'h77, 0, 32'hFFFF);
        run_op(32'h110, 1'b1, 2'd3, 1'b1, 1'b0, 32'h4000, 32'h0, 5'd3, 32'h99, 0, 32'h0);
        run_op(32'h114, 1'b0, 2'd1, 1'b1, 1'b1, 32'h5000, 32'h1, 5'd4, 32'h66, 0, 32'h0);

        // Timeout, then a bubble (error pulse must be gone), then ack on the last wait cycle
        run_op(32'h200, 1'b1, 2'd1, 1'b1, 1'b0, 32'h6000, 32'h0, 5'd8, 32'h88, -1, 32'h0);
        run_op(32'h204, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 32'h0);
        run_op(32'h208, 1'b1, 2'd1, 1'b1, 1'b0, 32'h6004, 32'h0, 5'd10, 32'h0, MAX_WAIT - 1, 32'hCAFEF00D);

        // Asynchronous reset during WAIT, then a stray ack in IDLE
        pc_i = 32'h500; have_inst_i = 1'b1; rf_wsel_i = 2'd1; rf_we_i = 1'b1; ram_we_i = 1'b0;
        alu_c_i = 32'h7000; wR_i = 5'd11; wD_i = 32'h500;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 64'(bus_req), 64'(1'b0));
        check("async_rst_pc", 64'(pc_o), 64'(0));
        check("async_rst_addr", 64'(bus_addr), 64'(0));
        check("async_rst_wr", 64'(wR_o), 64'(0));
        pc_i = '0; have_inst_i = 1'b0; rf_wsel_i = 2'd0; rf_we_i = 1'b0; wR_i = '0; wD_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        @(negedge clk);
        check("late_ack_stall", 64'(stall_o), 64'(1'b0));
        tick();
        bus_ack = 1'b0;
        check("late_ack_req", 64'(bus_req), 64'(1'b0));
        check("late_ack_err", 64'(bus_err_o), 64'(1'b0));
        check("late_ack_rf_we", 64'(rf_we_o), 64'(1'b0));
        check("late_ack_wd", 64'(wD_o), 64'(0));

        // Back-to-back loads: retire cycle of the first is the IDLE cycle of the second
        run_op(32'h300, 1'b1, 2'd1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd1, 32'h0, 0, 32'h0000AAAA);
        run_op(32'h304, 1'b1, 2'd1, 1'b1, 1'b0, 32'h14, 32'h0, 5'd2, 32'h0, 0, 32'h0000BBBB);

        for (int i = 0; i < 6; i++) begin
            run_op(32'h400 + 32'(i * 4), 1'b1, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                   $urandom, int'($urandom_range(0, 4)), $urandom);
        end

        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
